// File: rtl/operand_loader_pkg.sv
// Shared definitions for the operand loader: FSM state encodings, default
// operand width and the debounce counter sizing helper.
package operand_loader_pkg;

  localparam int OP_W_DEF = 2;

  localparam logic [1:0] WAIT_X = 2'b00;
  localparam logic [1:0] WAIT_Y = 2'b01;
  localparam logic [1:0] READY  = 2'b10;

  // Counter must be able to hold the value DEBOUNCE_CYCLES itself.
  function automatic int debounce_cnt_w(input int cycles);
    return (cycles < 1) ? 1 : $clog2(cycles + 1);
  endfunction

endpackage

// File: rtl/btn_debounce.sv
// Push-button conditioning: 2-flop synchroniser, optional debounce filter
// (OPERAND_LOADER_DEBOUNCE_EN) and a one-cycle press pulse on each debounced rise.
module btn_debounce
  import operand_loader_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 500000
) (
  input  logic clk,
  input  logic rst,
  input  logic btn,
  output logic press
);

  logic sync0_q, sync1_q;
  logic stable_q, stable_d;
  logic press_q, press_d;

  if (DEBOUNCE_CYCLES < 1) begin : g_bad_cycles
    $error("btn_debounce: DEBOUNCE_CYCLES must be >= 1");
  end

`ifdef OPERAND_LOADER_DEBOUNCE_EN
  localparam int               CNT_W   = debounce_cnt_w(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Any return to the stable level restarts the count, so bounces never accumulate.
  always_comb begin
    stable_d = stable_q;
    cnt_d    = '0;
    if (sync1_q != stable_q) begin
      if (cnt_q == CNT_MAX) stable_d = sync1_q;
      else                  cnt_d    = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end
`else
  assign stable_d = sync1_q;
`endif

  assign press_d = stable_d & ~stable_q;

  // NOTE: non-blocking assignments keep every flop sampling pre-edge values, which the synchroniser chain depends on.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync0_q  <= 1'b0;
      sync1_q  <= 1'b0;
      stable_q <= 1'b0;
      press_q  <= 1'b0;
    end else begin
      sync0_q  <= btn;
      sync1_q  <= sync0_q;
      stable_q <= stable_d;
      press_q  <= press_d;
    end
  end

  assign press = press_q;

endmodule

// File: rtl/operand_loader.sv
// Loads operands X then Y from one switch bank on debounced button presses.
// Debounce filter enabled by defining OPERAND_LOADER_DEBOUNCE_EN.
module operand_loader
  import operand_loader_pkg::*;
#(
  parameter int OP_W            = OP_W_DEF,
  parameter int DEBOUNCE_CYCLES = 500000
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [OP_W-1:0] sw,
  input  logic            btn,
  input  logic            clear,
  output logic [OP_W-1:0] op_x,
  output logic [OP_W-1:0] op_y,
  output logic            operands_valid,
  output logic [1:0]      load_state
);

  logic            press;
  logic [1:0]      state_q, state_d;
  logic [OP_W-1:0] op_x_q, op_x_d;
  logic [OP_W-1:0] op_y_q, op_y_d;
  logic            valid_q, valid_d;

  btn_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_btn_debounce (
    .clk  (clk),
    .rst  (rst),
    .btn  (btn),
    .press(press)
  );

  // NOTE: every variable gets its hold value first so no path through the case infers a latch.
  always_comb begin
    state_d = state_q;
    op_x_d  = op_x_q;
    op_y_d  = op_y_q;
    valid_d = valid_q;
    if (clear) begin
      state_d = WAIT_X;
      op_x_d  = '0;
      op_y_d  = '0;
      valid_d = 1'b0;
    end else begin
      case (state_q)
        WAIT_X: if (press) begin
          op_x_d  = sw;
          state_d = WAIT_Y;
        end
        WAIT_Y: if (press) begin
          op_y_d  = sw;
          valid_d = 1'b1;
          state_d = READY;
        end
        READY: if (press) begin
          op_x_d  = sw;
          valid_d = 1'b0;
          state_d = WAIT_Y;
        end
        default: begin
          state_d = WAIT_X;
          op_x_d  = '0;
          op_y_d  = '0;
          valid_d = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= WAIT_X;
      op_x_q  <= '0;
      op_y_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      op_x_q  <= op_x_d;
      op_y_q  <= op_y_d;
      valid_q <= valid_d;
    end
  end

  assign op_x           = op_x_q;
  assign op_y           = op_y_q;
  assign operands_valid = valid_q;
  assign load_state     = state_q;

endmodule

// File: tb/tb_operand_loader.sv
// Directed bench for operand_loader with DEBOUNCE_CYCLES=4; adapts its
// latency expectations to OPERAND_LOADER_DEBOUNCE_EN.
module tb_operand_loader;

  localparam int DB = 4;
`ifdef OPERAND_LOADER_DEBOUNCE_EN
  localparam int LAT = DB + 4;  // edges from driving btn to the output update
`else
  localparam int LAT = 4;
`endif
  localparam int REL = 12;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [1:0] sw = '0;
  logic       btn = 1'b0;
  logic       clear = 1'b0;
  logic [1:0] op_x, op_y;
  logic       operands_valid;
  logic [1:0] load_state;

  int n_cmp = 0;
  int n_bad = 0;

  operand_loader #(
    .OP_W           (2),
    .DEBOUNCE_CYCLES(DB)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .sw            (sw),
    .btn           (btn),
    .clear         (clear),
    .op_x          (op_x),
    .op_y          (op_y),
    .operands_valid(operands_valid),
    .load_state    (load_state)
  );

  always #5 clk = ~clk;

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; btn = 1'b0; clear = 1'b0;
    tick(2);
    rst = 1'b0;
  endtask

  task automatic press_btn(input logic [1:0] val);
    sw = val; btn = 1'b1;
    tick(10);
    btn = 1'b0;
    tick(REL);
  endtask

  task automatic expect_all(input string name, input logic [1:0] ex, input logic [1:0] ey,
                            input logic ev, input logic [1:0] es);
    n_cmp++;
    if ({op_x, op_y, operands_valid, load_state} !== {ex, ey, ev, es}) begin
      n_bad++;
      $display("FAIL %s: got x=%b y=%b v=%b st=%b, want x=%b y=%b v=%b st=%b",
               name, op_x, op_y, operands_valid, load_state, ex, ey, ev, es);
    end
  endtask

  task automatic test_reset();
    do_reset();
    n_cmp++; if (op_x !== 2'b00) begin n_bad++; $display("FAIL reset_op_x: got %b want 00", op_x); end
    n_cmp++; if (op_y !== 2'b00) begin n_bad++; $display("FAIL reset_op_y: got %b want 00", op_y); end
    n_cmp++; if (operands_valid !== 1'b0) begin n_bad++; $display("FAIL reset_valid: got %b want 0", operands_valid); end
    n_cmp++; if (load_state !== 2'b00) begin n_bad++; $display("FAIL reset_state: got %b want 00", load_state); end
  endtask

  task automatic test_basic_load();
    logic [3:0] dcba;
    logic [2:0] sum;
    sw = 2'b10; btn = 1'b1;
    tick(LAT - 1);
    expect_all("lat_before_edge", 2'b00, 2'b00, 1'b0, 2'b00);
    tick(1);
    expect_all("lat_at_edge", 2'b10, 2'b00, 1'b0, 2'b01);
    tick(10 - LAT);
    btn = 1'b0;
    tick(REL);
    press_btn(2'b11);
    expect_all("basic_load", 2'b10, 2'b11, 1'b1, 2'b10);
    dcba = {op_y[1], op_y[0], op_x[1], op_x[0]};
    sum  = {1'b0, op_x} + {1'b0, op_y};
    n_cmp++; if (dcba !== 4'b1110) begin n_bad++; $display("FAIL adder_inputs DCBA: got %b want 1110", dcba); end
    n_cmp++; if (sum !== 3'b101) begin n_bad++; $display("FAIL adder_sum: got %b want 101", sum); end
  endtask

  task automatic test_restart();
    press_btn(2'b01);
    expect_all("restart_from_ready", 2'b01, 2'b11, 1'b0, 2'b01);
    sw = 2'b00;
    tick(3);
    expect_all("sw_change_ignored", 2'b01, 2'b11, 1'b0, 2'b01);
  endtask

  task automatic test_clear_collision();
    sw = 2'b11; btn = 1'b1;
    tick(LAT - 1);
    clear = 1'b1;
    tick(1);
    clear = 1'b0;
    expect_all("clear_vs_press", 2'b00, 2'b00, 1'b0, 2'b00);
    tick(15);
    expect_all("held_no_repress", 2'b00, 2'b00, 1'b0, 2'b00);
    btn = 1'b0;
    tick(REL);
    press_btn(2'b10);
    expect_all("load_after_clear", 2'b10, 2'b00, 1'b0, 2'b01);
  endtask

  task automatic test_clear_mid_debounce();
    do_reset();
    sw = 2'b01; btn = 1'b1;
    tick(2);
    clear = 1'b1;
    tick(1);
    clear = 1'b0;
    tick(LAT - 4);
    expect_all("mid_clear_before", 2'b00, 2'b00, 1'b0, 2'b00);
    tick(1);
    expect_all("mid_clear_on_time", 2'b01, 2'b00, 1'b0, 2'b01);
    btn = 1'b0;
    tick(REL);
  endtask

  task automatic test_hold();
    do_reset();
    expect_all("reset_after_load", 2'b00, 2'b00, 1'b0, 2'b00);
    sw = 2'b01; btn = 1'b1;
    tick(50);
    expect_all("hold_single_press", 2'b01, 2'b00, 1'b0, 2'b01);
    btn = 1'b0;
    tick(REL);
    press_btn(2'b10);
    expect_all("press_after_release", 2'b01, 2'b10, 1'b1, 2'b10);
  endtask

`ifdef OPERAND_LOADER_DEBOUNCE_EN
  task automatic test_bounce();
    do_reset();
    sw = 2'b11;
    for (int i = 0; i < 5; i++) begin
      btn = 1'b1; tick(2);
      btn = 1'b0; tick(2);
    end
    expect_all("bounce_rejected", 2'b00, 2'b00, 1'b0, 2'b00);
    btn = 1'b1; tick(DB);
    btn = 1'b0; tick(REL);
    expect_all("short_hold_rejected", 2'b00, 2'b00, 1'b0, 2'b00);
    sw = 2'b01;
    btn = 1'b1; tick(DB + 1);
    btn = 1'b0; tick(REL);
    expect_all("min_hold_accepted", 2'b01, 2'b00, 1'b0, 2'b01);
    sw = 2'b10;
    for (int i = 0; i < 5; i++) begin
      btn = 1'b1; tick(2);
      btn = 1'b0; tick(2);
    end
    btn = 1'b1;
    tick(30);
    expect_all("bounce_then_steady", 2'b01, 2'b10, 1'b1, 2'b10);
    btn = 1'b0;
    tick(REL);
  endtask
`else
  task automatic test_single_pulse();
    do_reset();
    sw = 2'b10; btn = 1'b1;
    tick(1);
    btn = 1'b0;
    tick(2);
    expect_all("pulse_before_k3", 2'b00, 2'b00, 1'b0, 2'b00);
    tick(1);
    expect_all("pulse_at_k3", 2'b10, 2'b00, 1'b0, 2'b01);
    tick(REL);
  endtask
`endif

  initial begin
    test_reset();
    test_basic_load();
    test_restart();
    test_clear_collision();
    test_clear_mid_debounce();
    test_hold();
`ifdef OPERAND_LOADER_DEBOUNCE_EN
    test_bounce();
`else
    test_single_pulse();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
